// File: rtl/ppi_bus_sequencer.sv
// Two-port arbiter and bus-cycle sequencer in front of the 8255 PPI register interface.
// Define PPI_SEQ_FIXED_PRIO_EN for strict port-0 priority instead of round-robin arbitration.
module ppi_bus_sequencer #(
  parameter int STROBE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       ppi_cs_n,
  output logic       ppi_rd_n,
  output logic       ppi_wr_n,
  output logic [1:0] ppi_a,
  output logic [7:0] ppi_d_out,
  output logic       ppi_d_oe,
  input  logic [7:0] ppi_d_in
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       gnt, lat_we;
  logic [1:0] lat_addr;
  logic [7:0] lat_wdata, hold, rdata_q;
  logic       grant_vld, grant_idx;
  logic       nx_we, nx_ctrl, nx_active, nx_strobe;
  logic [1:0] nx_addr;
  logic [7:0] nx_wdata;

`ifdef PPI_SEQ_FIXED_PRIO_EN
  assign grant_idx = ~req0;
`else
  logic last;
  // the last-granted port loses a tie
  assign grant_idx = (req0 && req1) ? ~last : req1;
`endif
  assign grant_vld = req0 | req1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_vld) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (cnt == 4'd0) state_nx = RECOVER;
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Fields of the transaction as they will be next cycle, so pin outputs can be registered glitch-free.
  always_comb begin
    nx_we    = lat_we;
    nx_addr  = lat_addr;
    nx_wdata = lat_wdata;
    if (state == IDLE && grant_vld) begin
      nx_we    = grant_idx ? we1    : we0;
      nx_addr  = grant_idx ? addr1  : addr0;
      nx_wdata = grant_idx ? wdata1 : wdata0;
    end
    nx_ctrl   = (nx_addr == 2'd3);
    nx_active = (state_nx == SETUP) || (state_nx == STROBE);
    nx_strobe = (state_nx == STROBE) && !nx_ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 2'd0;
      lat_wdata <= 8'h00;
      hold      <= 8'h00;
      rdata_q   <= 8'h00;
`ifndef PPI_SEQ_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
      ppi_cs_n  <= 1'b1;
      ppi_rd_n  <= 1'b1;
      ppi_wr_n  <= 1'b1;
      ppi_a     <= 2'd0;
      ppi_d_out <= 8'h00;
      ppi_d_oe  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      state     <= state_nx;
      lat_we    <= nx_we;
      lat_addr  <= nx_addr;
      lat_wdata <= nx_wdata;
      if (state == IDLE && grant_vld) begin
        gnt  <= grant_idx;
`ifndef PPI_SEQ_FIXED_PRIO_EN
        last <= grant_idx;
`endif
      end
      if (state == SETUP) cnt <= CNT_INIT;
      else if (state == STROBE) cnt <= cnt - 4'd1;
      // control register reads never touch the bus and return all ones
      if (state == STROBE && cnt == 4'd0 && !lat_we)
        hold <= (lat_addr == 2'd3) ? 8'hFF : ppi_d_in;
      if (state == RECOVER && !lat_we) rdata_q <= hold;
      ppi_cs_n  <= !(nx_active && !nx_ctrl);
      ppi_rd_n  <= !(nx_strobe && !nx_we);
      ppi_wr_n  <= !(nx_strobe && nx_we);
      ppi_d_oe  <= nx_active && nx_we && !nx_ctrl;
      ppi_d_out <= (nx_active && nx_we && !nx_ctrl) ? nx_wdata : 8'h00;
      ppi_a     <= nx_active ? nx_addr : 2'd0;
      ack0      <= (state_nx == RECOVER) && !gnt;
      ack1      <= (state_nx == RECOVER) && gnt;
    end
  end

  assign rdata = (state == RECOVER && !lat_we) ? hold : rdata_q;
  assign busy  = (state != IDLE);
endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer: per-cycle pin checks plus an ack/rdata scoreboard,
// and strobe-width sweeps on STROBE_CYCLES=2 and 15 instances.
module tb_ppi_bus_sequencer;
  localparam int S = 3;

  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [1:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0, din = 0;
  logic ack0, ack1, busy, cs_n, rd_n, wr_n, doe;
  logic [7:0] rdata, dout;
  logic [1:0] a;

  logic req_s2 = 0, req_s15 = 0;
  logic s2_ack0, s2_ack1, s2_busy, s2_cs_n, s2_rd_n, s2_wr_n, s2_doe;
  logic s15_ack0, s15_ack1, s15_busy, s15_cs_n, s15_rd_n, s15_wr_n, s15_doe;
  logic [7:0] s2_rdata, s2_dout, s15_rdata, s15_dout;
  logic [1:0] s2_a, s15_a;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { bit port; logic [7:0] rd; int cyc; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ppi_bus_sequencer #(.STROBE_CYCLES(S)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ppi_cs_n(cs_n), .ppi_rd_n(rd_n), .ppi_wr_n(wr_n), .ppi_a(a),
    .ppi_d_out(dout), .ppi_d_oe(doe), .ppi_d_in(din));

  ppi_bus_sequencer #(.STROBE_CYCLES(2)) u_s2 (
    .clk(clk), .reset(reset), .req0(req_s2), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(2'd0), .addr1(2'd0), .wdata0(8'h00), .wdata1(8'h00),
    .ack0(s2_ack0), .ack1(s2_ack1), .rdata(s2_rdata), .busy(s2_busy),
    .ppi_cs_n(s2_cs_n), .ppi_rd_n(s2_rd_n), .ppi_wr_n(s2_wr_n), .ppi_a(s2_a),
    .ppi_d_out(s2_dout), .ppi_d_oe(s2_doe), .ppi_d_in(din));

  ppi_bus_sequencer #(.STROBE_CYCLES(15)) u_s15 (
    .clk(clk), .reset(reset), .req0(req_s15), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(2'd0), .addr1(2'd0), .wdata0(8'h00), .wdata1(8'h00),
    .ack0(s15_ack0), .ack1(s15_ack1), .rdata(s15_rdata), .busy(s15_busy),
    .ppi_cs_n(s15_cs_n), .ppi_rd_n(s15_rd_n), .ppi_wr_n(s15_wr_n), .ppi_a(s15_a),
    .ppi_d_out(s15_dout), .ppi_d_oe(s15_doe), .ppi_d_in(din));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit p, input bit w, input logic [1:0] ad, input logic [7:0] di, input int c);
    exp_t e;
    if (!w) last_rd = (ad == 2'd3) ? 8'hFF : di;
    e.port = p; e.rd = last_rd; e.cyc = c;
    q.push_back(e);
  endtask

  // Scoreboard for acks plus bus-protocol invariants, every cycle.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (q.size() == 0) chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("ack_port", {31'd0, ack1}, {31'd0, mon_e.port});
        chk("ack_cycle", cyc, mon_e.cyc);
        chk("ack_rdata", {24'd0, rdata}, {24'd0, mon_e.rd});
      end
    end
    chk("rd_wr_both_low", {31'd0, !rd_n && !wr_n}, 32'd0);
    chk("strobe_without_cs", {31'd0, (!rd_n || !wr_n) && cs_n}, 32'd0);
    chk("ack_both", {31'd0, ack0 && ack1}, 32'd0);
  end

  // Caller sits 1 time unit after a rising edge; that cycle is the IDLE sampling cycle N.
  task automatic run_txn(input bit p, input bit w, input logic [1:0] ad, input logic [7:0] wd, input logic [7:0] di);
    bit act, strb, ctrl;
    din = di;
    if (!p) begin req0 = 1; we0 = w; addr0 = ad; wdata0 = wd; end
    else    begin req1 = 1; we1 = w; addr1 = ad; wdata1 = wd; end
    push_exp(p, w, ad, di, cyc + S + 2);
    ctrl = (ad == 2'd3);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      act  = (k <= S + 1);
      strb = (k >= 2) && (k <= S + 1);
      chk($sformatf("cs_n k%0d", k), {31'd0, cs_n}, {31'd0, !(act && !ctrl)});
      chk($sformatf("rd_n k%0d", k), {31'd0, rd_n}, {31'd0, !(strb && !w && !ctrl)});
      chk($sformatf("wr_n k%0d", k), {31'd0, wr_n}, {31'd0, !(strb && w && !ctrl)});
      chk($sformatf("d_oe k%0d", k), {31'd0, doe}, {31'd0, act && w && !ctrl});
      if (act && w && !ctrl) chk($sformatf("d_out k%0d", k), {24'd0, dout}, {24'd0, wd});
      if (act) chk($sformatf("addr k%0d", k), {30'd0, a}, {30'd0, ad});
    end
    @(posedge clk); #1;
    if (!p) req0 = 0; else req1 = 0;
  endtask

  task automatic sweep(input bit sel, input int s, input logic [7:0] di);
    int low = 0, ackk = -1;
    logic [7:0] rd_at_ack = 8'h00;
    din = di;
    if (!sel) req_s2 = 1; else req_s15 = 1;
    for (int k = 0; k <= s + 2; k++) begin
      @(negedge clk);
      if (!(sel ? s15_rd_n : s2_rd_n)) low++;
      if ((sel ? s15_ack0 : s2_ack0) && ackk < 0) begin
        ackk = k;
        rd_at_ack = sel ? s15_rdata : s2_rdata;
      end
    end
    @(posedge clk); #1;
    req_s2 = 0; req_s15 = 0;
    chk($sformatf("sweep%0d_rd_width", s), low, s);
    chk($sformatf("sweep%0d_ack_cycle", s), ackk, s + 2);
    chk($sformatf("sweep%0d_rdata", s), {24'd0, rd_at_ack}, {24'd0, di});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_rd_n", {31'd0, rd_n}, 32'd1);
    chk("rst_wr_n", {31'd0, wr_n}, 32'd1);
    chk("rst_a", {30'd0, a}, 32'd0);
    chk("rst_d_out", {24'd0, dout}, 32'd0);
    chk("rst_d_oe", {31'd0, doe}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    run_txn(0, 0, 2'd0, 8'h00, 8'h5A);   // plain read
    run_txn(1, 1, 2'd1, 8'hC3, 8'h00);   // plain write
    run_txn(0, 0, 2'd3, 8'h00, 8'h12);   // control read -> FF
    run_txn(1, 1, 2'd3, 8'h55, 8'h00);   // control write discarded

    // contention: both held; last grant was port 1 so port 0 leads
    n = cyc;
    din = 8'h3C;
    req0 = 1; we0 = 0; addr0 = 2'd0;
    req1 = 1; we1 = 0; addr1 = 2'd1;
    for (int i = 0; i < 4; i++) begin
`ifdef PPI_SEQ_FIXED_PRIO_EN
      push_exp(1'b0, 1'b0, 2'd0, 8'h3C, n + 5 + 6 * i);
`else
      push_exp(i[0], 1'b0, 2'd0, 8'h3C, n + 5 + 6 * i);
`endif
    end
    repeat (24) @(posedge clk);
    #1 req0 = 0; req1 = 0;
    @(posedge clk); #1;

    // reset in the second STROBE cycle of a port-1 write
    n = cyc;
    req1 = 1; we1 = 1; addr1 = 2'd1; wdata1 = 8'hAA;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    last_rd = 8'h00;
    din = 8'h77;
    req0 = 1; we0 = 0; addr0 = 2'd2;
    push_exp(1'b0, 1'b0, 2'd2, 8'h77, n + 9);
    push_exp(1'b1, 1'b1, 2'd1, 8'h00, n + 15);
    @(negedge clk);
    chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
    chk("abort_wr_n", {31'd0, wr_n}, 32'd1);
    chk("abort_rd_n", {31'd0, rd_n}, 32'd1);
    chk("abort_d_oe", {31'd0, doe}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", {24'd0, rdata}, 32'd0);
    repeat (6) @(posedge clk);
    #1 req0 = 0;
    repeat (6) @(posedge clk);
    #1 req1 = 0;
    repeat (3) @(posedge clk);
    #1;

    sweep(1'b0, 2, 8'h9E);
    sweep(1'b1, 15, 8'h61);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
